// File: rtl/rf_write_scheduler_pkg.sv
// Shared constants, types and helpers for the register-file write scheduler.
// The package name is rf_sched_pkg; every scheduler file imports it.
package rf_sched_pkg;

    localparam int NREGS = 16;
    localparam int DW    = 16;
    localparam int RW    = 4;

    // Round-robin pointer values: which side wins the next tie.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_t;

    // Grant-vector bit positions.
    localparam int GNT_ALU = 0;
    localparam int GNT_MEM = 1;

    // One-hot register mask, used for both scoreboard set and clear.
    function automatic logic [NREGS-1:0] decode4to16(input logic [RW-1:0] reg_id);
        logic [NREGS-1:0] mask;
        mask         = '0;
        mask[reg_id] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Bundles the reserve, source-lookup, writeback and register-file signals
// of the scheduler; master = issue/decode/execute side, slave = scheduler.
interface rf_write_scheduler_if;
    import rf_sched_pkg::*;

    logic             reserve_valid;
    logic [RW-1:0]    reserve_reg;
    logic             reserve_ready;

    logic [RW-1:0]    src1_reg;
    logic [RW-1:0]    src2_reg;
    logic             src1_busy;
    logic             src2_busy;

    logic             alu_wr_valid;
    logic [RW-1:0]    alu_wr_reg;
    logic [DW-1:0]    alu_wr_data;
    logic             alu_wr_ready;

    logic             mem_wr_valid;
    logic [RW-1:0]    mem_wr_reg;
    logic [DW-1:0]    mem_wr_data;
    logic             mem_wr_ready;

    logic             rf_WriteReg;
    logic [RW-1:0]    rf_DstReg;
    logic [DW-1:0]    rf_DstData;
    logic [NREGS-1:0] busy_mask;

    modport master (
        output reserve_valid, reserve_reg,
        output src1_reg, src2_reg,
        output alu_wr_valid, alu_wr_reg, alu_wr_data,
        output mem_wr_valid, mem_wr_reg, mem_wr_data,
        input  reserve_ready, src1_busy, src2_busy,
        input  alu_wr_ready, mem_wr_ready,
        input  rf_WriteReg, rf_DstReg, rf_DstData, busy_mask
    );

    modport slave (
        input  reserve_valid, reserve_reg,
        input  src1_reg, src2_reg,
        input  alu_wr_valid, alu_wr_reg, alu_wr_data,
        input  mem_wr_valid, mem_wr_reg, mem_wr_data,
        output reserve_ready, src1_busy, src2_busy,
        output alu_wr_ready, mem_wr_ready,
        output rf_WriteReg, rf_DstReg, rf_DstData, busy_mask
    );

endinterface

// File: rtl/rf_write_scheduler_rr_arbiter_2.sv
// Two-requester round-robin arbiter: one-hot grant vector, pointer flips to
// the losing side after every grant and holds on idle cycles.
module rr_arbiter_2
    import rf_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    req_t       r_ptr_reg;
    req_t       w_ptr_next;
    logic [1:0] w_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_reg <= REQ_ALU;
        end else begin
            r_ptr_reg <= w_ptr_next;
        end
    end

    always_comb begin
        w_ptr_next = r_ptr_reg;
        if (w_gnt[GNT_ALU]) begin
            w_ptr_next = REQ_MEM;
        end else if (w_gnt[GNT_MEM]) begin
            w_ptr_next = REQ_ALU;
        end
    end

    // Grants are suppressed while reset is asserted so nothing is consumed.
    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = (r_ptr_reg == REQ_ALU) ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/rf_write_scheduler.sv
// Write-port scheduler: arbitrates ALU/MEM writebacks onto the register file,
// registers the winning write and keeps a per-register busy scoreboard.
module rf_write_scheduler
    import rf_sched_pkg::*;
#(
    parameter int NREGS = rf_sched_pkg::NREGS,
    parameter int DW    = rf_sched_pkg::DW,
    parameter int RW    = rf_sched_pkg::RW
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_write_scheduler_if.slave  bus
);

    logic [1:0]       w_gnt;
    logic             w_wr_en;
    logic [RW-1:0]    w_wr_dst;
    logic [DW-1:0]    w_wr_data;

    logic             w_res_ready;
    logic             w_res_accept;
    logic             w_src1_busy;
    logic             w_src2_busy;

    logic [NREGS-1:0] r_busy_reg;
    logic [NREGS-1:0] w_busy_next;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_clr_mask;

    logic             r_we_reg;
    logic [RW-1:0]    r_dst_reg;
    logic [DW-1:0]    r_data_reg;

    rr_arbiter_2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req ({bus.mem_wr_valid, bus.alu_wr_valid}),
        .o_gnt (w_gnt)
    );

    assign w_wr_en   = |w_gnt;
    assign w_wr_dst  = w_gnt[GNT_MEM] ? bus.mem_wr_reg  : bus.alu_wr_reg;
    assign w_wr_data = w_gnt[GNT_MEM] ? bus.mem_wr_data : bus.alu_wr_data;

    // A same-cycle write to the claimed register frees it, so the claim may proceed.
    assign w_res_ready  = !rst &&
                          (!r_busy_reg[bus.reserve_reg] ||
                           (w_wr_en && (w_wr_dst == bus.reserve_reg)));
    assign w_res_accept = bus.reserve_valid && w_res_ready;

    assign w_src1_busy = r_busy_reg[bus.src1_reg] && !(w_wr_en && (w_wr_dst == bus.src1_reg));
    assign w_src2_busy = r_busy_reg[bus.src2_reg] && !(w_wr_en && (w_wr_dst == bus.src2_reg));

    assign w_set_mask = w_res_accept ? decode4to16(bus.reserve_reg) : '0;
    assign w_clr_mask = w_wr_en      ? decode4to16(w_wr_dst)        : '0;

    // Set has priority over clear when a reserve and a write hit the same register.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
            assign w_busy_next[gi] = w_set_mask[gi] | (r_busy_reg[gi] & ~w_clr_mask[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_reg <= '0;
        end else begin
            r_busy_reg <= w_busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we_reg   <= 1'b0;
            r_dst_reg  <= '0;
            r_data_reg <= '0;
        end else begin
            r_we_reg <= w_wr_en;
            if (w_wr_en) begin
                r_dst_reg  <= w_wr_dst;
                r_data_reg <= w_wr_data;
            end
        end
    end

    assign bus.reserve_ready = w_res_ready;
    assign bus.src1_busy     = w_src1_busy;
    assign bus.src2_busy     = w_src2_busy;
    assign bus.alu_wr_ready  = w_gnt[GNT_ALU];
    assign bus.mem_wr_ready  = w_gnt[GNT_MEM];
    assign bus.rf_WriteReg   = r_we_reg;
    assign bus.rf_DstReg     = r_dst_reg;
    assign bus.rf_DstData    = r_data_reg;
    assign bus.busy_mask     = r_busy_reg;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed scenarios followed by randomized traffic for rf_write_scheduler,
// checked against a queue/array reference model with a decoupled output monitor.
module tb_rf_write_scheduler;
    import rf_sched_pkg::*;

    logic clk = 1'b0;
    logic rst;

    rf_write_scheduler_if bus ();

    rf_write_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] dst;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: busy flags per register, which side wins a tie,
    // and the last values presented to the register file.
    bit          m_busy[NREGS];
    int          m_prefer_mem;
    logic [31:0] m_last_dst;
    logic [31:0] m_last_data;
    bit          g_alu;
    bit          g_mem;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mask_of();
        logic [31:0] m = 0;
        for (int i = 0; i < NREGS; i++) if (m_busy[i]) m = m + (32'd1 << i);
        return m;
    endfunction

    // One clock cycle: drive inputs, check combinational outputs against the
    // model, queue the expected register-file output, advance the model.
    task automatic cycle(input bit r, input bit rv, input int rreg, input int s1, input int s2,
                         input bit av, input int ar, input int ad,
                         input bit mv, input int mr, input int md);
        bit wen;
        int wdst;
        int wdata;
        bit res_ok;
        exp_t e;
        @(negedge clk);
        rst               = r;
        bus.reserve_valid = rv;
        bus.reserve_reg   = 4'(rreg);
        bus.src1_reg      = 4'(s1);
        bus.src2_reg      = 4'(s2);
        bus.alu_wr_valid  = av;
        bus.alu_wr_reg    = 4'(ar);
        bus.alu_wr_data   = 16'(ad);
        bus.mem_wr_valid  = mv;
        bus.mem_wr_reg    = 4'(mr);
        bus.mem_wr_data   = 16'(md);
        #1;
        chk("busy_mask", bus.busy_mask, mask_of());

        g_alu = 0;
        g_mem = 0;
        if (!r) begin
            if (av && mv) begin
                if (m_prefer_mem != 0) g_mem = 1;
                else                   g_alu = 1;
            end else begin
                g_alu = av;
                g_mem = mv;
            end
        end
        wen   = g_alu || g_mem;
        wdst  = g_mem ? mr : ar;
        wdata = g_mem ? md : ad;
        res_ok = !r && (!m_busy[rreg] || (wen && wdst == rreg));

        chk("alu_wr_ready", bus.alu_wr_ready, g_alu);
        chk("mem_wr_ready", bus.mem_wr_ready, g_mem);
        chk("reserve_ready", bus.reserve_ready, res_ok);
        chk("src1_busy", bus.src1_busy, m_busy[s1] && !(wen && wdst == s1));
        chk("src2_busy", bus.src2_busy, m_busy[s2] && !(wen && wdst == s2));

        if (r) begin
            m_last_dst  = 0;
            m_last_data = 0;
            e = '{we: 1'b0, dst: 0, data: 0};
        end else if (wen) begin
            m_last_dst  = wdst;
            m_last_data = wdata;
            e = '{we: 1'b1, dst: wdst, data: wdata};
        end else begin
            e = '{we: 1'b0, dst: m_last_dst, data: m_last_data};
        end
        exp_q.push_back(e);

        if (r) begin
            for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
            m_prefer_mem = 0;
        end else begin
            if (wen) begin
                m_busy[wdst] = 0;
                m_prefer_mem = g_alu ? 1 : 0;
            end
            if (rv && res_ok) m_busy[rreg] = 1;
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares the registered write-port outputs one edge after issue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_WriteReg", {31'd0, bus.rf_WriteReg}, {31'd0, e.we});
                chk("rf_DstReg", bus.rf_DstReg, e.dst);
                chk("rf_DstData", bus.rf_DstData, e.data);
                if (bus.rf_WriteReg)
                    $display("write r%0d <= 0x%04h at %0t", bus.rf_DstReg, bus.rf_DstData, $time);
            end
        end
    end

    initial begin
        bit av, mv, r;
        int ar, ad, mr, md;

        rst               = 1'b1;
        bus.reserve_valid = 1'b0;
        bus.reserve_reg   = '0;
        bus.src1_reg      = '0;
        bus.src2_reg      = '0;
        bus.alu_wr_valid  = 1'b0;
        bus.alu_wr_reg    = '0;
        bus.alu_wr_data   = '0;
        bus.mem_wr_valid  = 1'b0;
        bus.mem_wr_reg    = '0;
        bus.mem_wr_data   = '0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
        m_prefer_mem = 0;
        m_last_dst   = 0;
        m_last_data  = 0;

        // Reset with everything requesting: no readies.
        cycle(1, 1, 2, 0, 0, 1, 1, 'h1111, 1, 2, 'h2222);
        chk("rst_reserve_ready", bus.reserve_ready, 0);
        chk("rst_alu_ready", bus.alu_wr_ready, 0);

        // Dual contention straight out of reset alternates ALU, MEM, ALU, MEM.
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 0, 1, 1, 'h1111, 1, 2, 'h2222);
            chk("contention_alu_ready", bus.alu_wr_ready, (i % 2 == 0));
        end

        // ALU only: reserve R5, see it busy, then the write clears it.
        cycle(0, 1, 5, 5, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        chk("src1_busy_before_grant", bus.src1_busy, 1);
        cycle(0, 0, 0, 5, 0, 1, 5, 'hBEEF, 0, 0, 0);
        chk("src1_busy_grant_cycle", bus.src1_busy, 0);
        idle();
        chk("busy5_cleared", bus.busy_mask[5], 0);

        // WAW: second claim on R3 stalls until a write to R3 is granted.
        cycle(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("waw_first_reserve", bus.reserve_ready, 1);
        cycle(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("waw_stall", bus.reserve_ready, 0);
        cycle(0, 1, 3, 0, 0, 0, 0, 0, 1, 3, 'h3333);
        chk("waw_release", bus.reserve_ready, 1);
        idle();
        chk("busy3_set_wins", bus.busy_mask[3], 1);

        // Held request: MEM loses once, holds, then is granted exactly once.
        cycle(0, 0, 0, 0, 0, 1, 6, 'h0066, 1, 7, 'h00AA);
        chk("held_mem_lost", bus.mem_wr_ready, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 'h00AA);
        chk("held_mem_granted", bus.mem_wr_ready, 1);
        idle();

        // Mid-operation reset with 0x00F0 reserved and grants pending.
        cycle(0, 0, 0, 0, 0, 1, 3, 'h0003, 0, 0, 0);
        for (int i = 4; i < 8; i++) cycle(0, 1, i, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("pre_reset_mask", bus.busy_mask, 'h00F0);
        cycle(1, 0, 0, 0, 0, 1, 4, 'h4444, 1, 5, 'h5555);
        cycle(0, 0, 0, 0, 0, 1, 4, 'h4444, 1, 5, 'h5555);
        chk("post_reset_mask", bus.busy_mask, 0);
        chk("post_reset_ptr_alu", bus.alu_wr_ready, 1);
        idle();

        // Randomized traffic with hold-until-granted requesters.
        av = 0;
        mv = 0;
        ar = 0; ad = 0; mr = 0; md = 0;
        repeat (400) begin
            if (!av && $urandom_range(0, 99) < 55) begin
                av = 1; ar = $urandom_range(0, 7); ad = $urandom_range(0, 65535);
            end
            if (!mv && $urandom_range(0, 99) < 55) begin
                mv = 1; mr = $urandom_range(0, 7); md = $urandom_range(0, 65535);
            end
            r = ($urandom_range(0, 99) < 2);
            cycle(r, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                  $urandom_range(0, 15), $urandom_range(0, 15), av, ar, ad, mv, mr, md);
            if (r || g_alu) av = 0;
            if (r || g_mem) mv = 0;
        end

        repeat (2) idle();
        @(negedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_write_scheduler.md
# rf_write_scheduler

Write-port scheduler and scoreboard for the 16×16-bit register file. Arbitrates the ALU and memory writeback paths onto the file's single write port with round-robin fairness. Registers the winning write into the file's WriteReg/DstReg/DstData inputs. Tracks a busy bit per register, reserved at issue and released at writeback, so decode can stall on RAW and WAW hazards.

## Interface
Parameters:
- NREGS, 16, register count (fixed; sets busy-mask width)
- DW, 16, data width
- RW, 4, register-ID width (log2 NREGS)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- reserve_valid  in  1  issue stage claims a destination register
- reserve_reg  in  4  destination being claimed
- reserve_ready  out  1  claim accepted this cycle (combinational)
- src1_reg, src2_reg  in  4 each  decode source IDs
- src1_busy, src2_busy  out  1 each  source has a pending write (combinational)
- alu_wr_valid  in  1  ALU writeback request
- alu_wr_reg  in  4  ALU writeback destination
- alu_wr_data  in  16  ALU writeback data
- alu_wr_ready  out  1  ALU writeback granted (combinational)
- mem_wr_valid, mem_wr_reg, mem_wr_data, mem_wr_ready  same as the ALU set, for the load path
- rf_WriteReg  out  1  registered write enable to the register file
- rf_DstReg  out  4  registered destination
- rf_DstData  out  16  registered data
- busy_mask  out  16  current scoreboard state, for debug and verification

## Operation
- Handshake: a transfer occurs on a cycle where valid && ready. The requester must hold reg and data stable while valid && !ready.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the side named by rr_ptr is granted.
  - After any grant, rr_ptr points to the non-granted side.
  - rr_ptr is unchanged on idle cycles.
- Output register: on a grant, the next edge loads rf_WriteReg=1 and rf_DstReg/rf_DstData from the winner. With no grant, rf_WriteReg=0 and rf_DstReg/rf_DstData hold their values.
- Scoreboard set/clear:
  - busy[r] is set on an accepted reserve.
  - busy[r] is cleared on a granted write to r.
  - A write to a non-busy register is legal and leaves the mask unchanged.
- Reserve gating: reserve_ready = !busy[reserve_reg] || (a write to reserve_reg is granted this cycle). This stalls WAW.
- Simultaneous events on the same register:
  - A grant clears r and an accepted reserve sets r in the same cycle: the set wins, so busy stays 1.
  - Both requesters target the same r: only the winner clears busy. The loser is not checked against the mask.
- Source busy: srcN_busy = busy[srcN_reg] && !(granted write to srcN_reg this cycle). The data reaches the file on the next edge, and the file's read bypass handles that cycle.
- Register 0 has no special treatment.

## Timing
- Reset (synchronous, on an edge with rst=1): busy_mask=0, rr_ptr=ALU, rf_WriteReg=0, rf_DstReg=0, rf_DstData=0.
- During rst=1, readies are forced to 0 and no reserve or grant takes effect.
- Reset mid-operation discards any grant in that cycle. Outstanding reservations are lost. Requesters must re-present after rst falls.
- Latency: grant in cycle N gives rf_WriteReg=1 in cycle N+1. The file commits at the N+2 edge, and busy clears at the N+1 edge.
- Throughput: one write per cycle. Under continuous dual contention, the sides strictly alternate.
- readies and srcN_busy are combinational from inputs and state. No output depends combinationally on rf_* outputs.

## Structure
- Package rf_sched_pkg holds:
  - constants NREGS=16, DW=16, RW=4
  - enum req_t {REQ_ALU=0, REQ_MEM=1} for rr_ptr
  - helper function decode4to16 for the set/clear masks
- Natural sub-module: rr_arbiter_2, a two-requester round-robin with grant-vector output and pointer state.
- The top level holds the scoreboard, reserve gating, and output register.

## Test plan
- Reset then idle: busy_mask=0x0000, rf_WriteReg=0 and all readies 0 while rst=1. After release, alu_wr_ready=1 whenever alu_wr_valid=1.
- ALU only: reserve R5, then ALU writes R5=0xBEEF. Next cycle rf_WriteReg=1, rf_DstReg=5, rf_DstData=0xBEEF, busy_mask bit 5 clears; src1_reg=5 gives src1_busy=1 before the grant and 0 in the grant cycle.
- Contention: ALU (R1=0x1111) and MEM (R2=0x2222) valid for 4 cycles from reset. Grants go ALU, MEM, ALU, MEM, and rf_DstReg sequence is 1,2,1,2.
- WAW stall: reserve R3 accepted, second reserve R3 gives reserve_ready=0. MEM writes R3 in cycle N gives reserve_ready=1 in cycle N, and busy bit 3 remains 1 afterwards.
- Held request: MEM valid with R7=0x00AA loses to ALU. It holds, is granted next cycle, rf_DstData=0x00AA, and is never written twice.
- Mid-operation reset: busy_mask=0x00F0 with a grant pending, rst=1 for one cycle. Next cycle busy_mask=0, rf_WriteReg=0, rr_ptr=ALU.
